// File: rtl/pipe_stage_buf_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stage_buf_pkg : shared rv32i pipe widths and handshake transfer types
// Rev 1.0
// ---------------------------------------------------------------------------
package pipe_stage_buf_pkg;

  // Default payload width for every stage of the rv32i pipe.
  localparam int unsigned PIPE_XLEN = 32;

  // Per-cycle transfer kind on a stage buffer, encoded as {pop, push}.
  typedef enum logic [1:0] {
    XFER_IDLE = 2'b00,
    XFER_PUSH = 2'b01,
    XFER_POP  = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_e;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stage_buf : elastic DEPTH-entry pipeline stage with registered stall
// Rev 1.0
// ---------------------------------------------------------------------------
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter  int unsigned XLEN  = PIPE_XLEN,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            clear_i,
  input  logic            data_ready_i,
  input  logic [XLEN-1:0] data_i,
  output logic            execute_o,
  output logic            stall_o,
  output logic            data_ready_o,
  output logic [XLEN-1:0] data_o,
  input  logic            downstream_execute_i,
  input  logic            hold_i,
  output logic [CW-1:0]   level_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            push, pop, flush;
  xfer_e           xfer;

  // Compare-based wrap keeps non-power-of-two depths legal.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign flush        = reset_i | clear_i;
  assign stall_o      = full_q;
  assign execute_o    = data_ready_i & ~full_q & ~flush;
  assign data_ready_o = (count_q != '0) & ~hold_i;
  assign data_o       = mem_q[rd_ptr_q];
  assign level_o      = count_q;
  assign push         = execute_o;
  assign pop          = downstream_execute_i & data_ready_o & ~flush;

  always_comb begin
    xfer     = xfer_e'({pop, push});
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    case (xfer)
      XFER_PUSH: count_d = count_q + CW'(1);
      XFER_POP:  count_d = count_q - CW'(1);
      default:   count_d = count_q;
    endcase
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      full_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      full_q   <= full_d;
    end
  end

  // Payload survives clear_i; only reset_i scrubs it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_stage_buf : directed bench, DEPTH=2 (dut a) and DEPTH=3 (dut b)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_clr, a_dr, a_ex, a_st, a_dro, a_dex, a_hold;
  logic [31:0] a_d, a_do;
  logic [1:0]  a_lvl;
  logic        b_clr, b_dr, b_ex, b_st, b_dro, b_dex, b_hold;
  logic [31:0] b_d, b_do;
  logic [1:0]  b_lvl;

  int n_cmp = 0;
  int n_fail = 0;

  pipe_stage_buf #(.XLEN(32), .DEPTH(2)) dut_a (
    .clk_i(clk), .reset_i(rst), .clear_i(a_clr), .data_ready_i(a_dr),
    .data_i(a_d), .execute_o(a_ex), .stall_o(a_st), .data_ready_o(a_dro),
    .data_o(a_do), .downstream_execute_i(a_dex), .hold_i(a_hold), .level_o(a_lvl)
  );

  pipe_stage_buf #(.XLEN(32), .DEPTH(3)) dut_b (
    .clk_i(clk), .reset_i(rst), .clear_i(b_clr), .data_ready_i(b_dr),
    .data_i(b_d), .execute_o(b_ex), .stall_o(b_st), .data_ready_o(b_dro),
    .data_o(b_do), .downstream_execute_i(b_dex), .hold_i(b_hold), .level_o(b_lvl)
  );

  // Inputs change 1ns after the rising edge; outputs are checked at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_dr = 1'b1; b_dr = 1'b1; a_d = 32'h55; b_d = 32'h66;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (a_ex !== 1'b0) begin n_fail++; $display("FAIL reset_exec_a: got %b want 0", a_ex); end
      n_cmp++; if (b_ex !== 1'b0) begin n_fail++; $display("FAIL reset_exec_b: got %b want 0", b_ex); end
      next_cycle();
    end
    rst = 1'b0; a_dr = 1'b0; b_dr = 1'b0;
    @(negedge clk);
    n_cmp++; if ({a_dro, a_st, a_lvl} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl_a: got %b want 0000", {a_dro, a_st, a_lvl}); end
    n_cmp++; if ({b_dro, b_st, b_lvl} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl_b: got %b want 0000", {b_dro, b_st, b_lvl}); end
    n_cmp++; if (a_do !== 32'h0) begin n_fail++; $display("FAIL reset_data_a: got %h want 0", a_do); end
    n_cmp++; if (b_do !== 32'h0) begin n_fail++; $display("FAIL reset_data_b: got %h want 0", b_do); end
    next_cycle();
  endtask

  task automatic test_streaming();
    for (int k = 0; k < 8; k++) begin
      a_dr = 1'b1; a_d = 32'(k + 1); a_dex = 1'b1;
      @(negedge clk);
      n_cmp++; if (a_ex !== 1'b1 || a_st !== 1'b0) begin n_fail++; $display("FAIL stream_accept[%0d]: got ex=%b st=%b want ex=1 st=0", k, a_ex, a_st); end
      n_cmp++; if (a_dro !== (k >= 1)) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want %b", k, a_dro, (k >= 1)); end
      n_cmp++; if (a_lvl !== ((k >= 1) ? 2'd1 : 2'd0)) begin n_fail++; $display("FAIL stream_level[%0d]: got %0d", k, a_lvl); end
      if (k >= 1) begin
        n_cmp++; if (a_do !== 32'(k)) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", k, a_do, k); end
      end
      next_cycle();
    end
    a_dr = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_dro !== 1'b1 || a_do !== 32'h8) begin n_fail++; $display("FAIL stream_last: got v=%b d=%h want v=1 d=8", a_dro, a_do); end
    next_cycle();
    a_dex = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_lvl !== 2'd0 || a_dro !== 1'b0) begin n_fail++; $display("FAIL stream_empty: got lvl=%0d v=%b want 0 0", a_lvl, a_dro); end
    next_cycle();
  endtask

  task automatic test_fill_drain();
    logic [31:0] vals [4];
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC; vals[3] = 32'hD;
    b_dex = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_dr = 1'b1; b_d = vals[i];
      @(negedge clk);
      n_cmp++; if (b_ex !== 1'b1) begin n_fail++; $display("FAIL fill_push[%0d]: got %b want 1", i, b_ex); end
      next_cycle();
    end
    b_d = vals[3];
    @(negedge clk);
    n_cmp++; if (b_lvl !== 2'd3 || b_st !== 1'b1 || b_ex !== 1'b0) begin n_fail++; $display("FAIL fill_full: got lvl=%0d st=%b ex=%b want 3 1 0", b_lvl, b_st, b_ex); end
    next_cycle();
    b_dex = 1'b1;
    @(negedge clk);
    n_cmp++; if (b_st !== 1'b1 || b_ex !== 1'b0 || b_do !== 32'hA) begin n_fail++; $display("FAIL fill_pop_full: got st=%b ex=%b d=%h want 1 0 a", b_st, b_ex, b_do); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (b_st !== 1'b0 || b_ex !== 1'b1 || b_lvl !== 2'd2) begin n_fail++; $display("FAIL fill_unstall: got st=%b ex=%b lvl=%0d want 0 1 2", b_st, b_ex, b_lvl); end
    n_cmp++; if (b_do !== 32'hB) begin n_fail++; $display("FAIL drain_B: got %h want b", b_do); end
    next_cycle();
    b_dr = 1'b0;
    for (int i = 2; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (b_dro !== 1'b1 || b_do !== vals[i]) begin n_fail++; $display("FAIL drain[%0d]: got v=%b d=%h want 1 %h", i, b_dro, b_do, vals[i]); end
      next_cycle();
    end
    @(negedge clk);
    n_cmp++; if (b_lvl !== 2'd0 || b_dro !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got lvl=%0d v=%b", b_lvl, b_dro); end
    b_dex = 1'b0;
    next_cycle();
  endtask

  task automatic test_wrap();
    int popn = 0;
    for (int i = 0; i < 12; i++) begin
      b_dr  = (i < 10);
      b_d   = 32'h100 + 32'(i);
      b_dex = (i >= 2);
      @(negedge clk);
      if (i < 10) begin
        n_cmp++; if (b_ex !== 1'b1) begin n_fail++; $display("FAIL wrap_exec[%0d]: got %b want 1", i, b_ex); end
        n_cmp++; if (b_lvl !== ((i == 0) ? 2'd0 : (i == 1) ? 2'd1 : 2'd2)) begin n_fail++; $display("FAIL wrap_level[%0d]: got %0d", i, b_lvl); end
      end
      if (b_dex && b_dro) begin
        n_cmp++; if (b_do !== 32'h100 + 32'(popn)) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", popn, b_do, 32'h100 + 32'(popn)); end
        popn++;
      end
      next_cycle();
    end
    b_dex = 1'b0;
    n_cmp++; if (popn !== 10) begin n_fail++; $display("FAIL wrap_count: got %0d want 10", popn); end
  endtask

  task automatic test_hold();
    a_dr = 1'b1; a_d = 32'h77; a_dex = 1'b0; a_hold = 1'b0;
    next_cycle();
    a_dr = 1'b0; a_dex = 1'b1; a_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (a_dro !== 1'b0 || a_lvl !== 2'd1) begin n_fail++; $display("FAIL hold_block[%0d]: got v=%b lvl=%0d want 0 1", i, a_dro, a_lvl); end
      next_cycle();
    end
    a_dr = 1'b1; a_d = 32'h78;
    next_cycle();
    a_d = 32'h79;
    @(negedge clk);
    n_cmp++; if (a_lvl !== 2'd2 || a_st !== 1'b1 || a_ex !== 1'b0) begin n_fail++; $display("FAIL hold_fill: got lvl=%0d st=%b ex=%b want 2 1 0", a_lvl, a_st, a_ex); end
    next_cycle();
    a_dr = 1'b0; a_hold = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_dro !== 1'b1 || a_do !== 32'h77) begin n_fail++; $display("FAIL hold_release0: got v=%b d=%h want 1 77", a_dro, a_do); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (a_dro !== 1'b1 || a_do !== 32'h78) begin n_fail++; $display("FAIL hold_release1: got v=%b d=%h want 1 78", a_dro, a_do); end
    next_cycle();
    a_dex = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_lvl !== 2'd0) begin n_fail++; $display("FAIL hold_empty: got %0d want 0", a_lvl); end
    next_cycle();
  endtask

  task automatic test_clear();
    b_dex = 1'b0; b_dr = 1'b1; b_d = 32'h21;
    next_cycle();
    b_d = 32'h22;
    next_cycle();
    b_d = 32'h23; b_dex = 1'b1; b_clr = 1'b1;
    @(negedge clk);
    n_cmp++; if (b_ex !== 1'b0 || b_lvl !== 2'd2) begin n_fail++; $display("FAIL clear_exec: got ex=%b lvl=%0d want 0 2", b_ex, b_lvl); end
    next_cycle();
    b_clr = 1'b0; b_dr = 1'b0; b_dex = 1'b0;
    @(negedge clk);
    n_cmp++; if (b_lvl !== 2'd0 || b_dro !== 1'b0 || b_st !== 1'b0) begin n_fail++; $display("FAIL clear_state: got lvl=%0d v=%b st=%b want 0 0 0", b_lvl, b_dro, b_st); end
    next_cycle();
    b_dr = 1'b1; b_d = 32'h31;
    @(negedge clk);
    n_cmp++; if (b_ex !== 1'b1 || b_dro !== 1'b0) begin n_fail++; $display("FAIL clear_push: got ex=%b v=%b want 1 0", b_ex, b_dro); end
    next_cycle();
    b_dr = 1'b0; b_dex = 1'b1;
    @(negedge clk);
    n_cmp++; if (b_dro !== 1'b1 || b_do !== 32'h31 || b_lvl !== 2'd1) begin n_fail++; $display("FAIL clear_first: got v=%b d=%h lvl=%0d want 1 31 1", b_dro, b_do, b_lvl); end
    next_cycle();
    b_dex = 1'b0;
    @(negedge clk);
    n_cmp++; if (b_lvl !== 2'd0) begin n_fail++; $display("FAIL clear_drain: got %0d want 0", b_lvl); end
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    a_clr = 1'b0; a_dr = 1'b0; a_d = '0; a_dex = 1'b0; a_hold = 1'b0;
    b_clr = 1'b0; b_dr = 1'b0; b_d = '0; b_dex = 1'b0; b_hold = 1'b0;
    #1;
    test_reset();
    test_streaming();
    test_fill_drain();
    test_wrap();
    test_hold();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
